// File: rtl/tach_quad_counter_if.sv
`default_nettype none
// ============================================================================
//  Module      : tach_quad_counter_if
//  Description : Control, tach and presented-count signals of one motor
//                channel's quadrature tachometer front end.
//  Revision    : 1.0  initial release
// ============================================================================
interface tach_quad_counter_if;
    logic       filterce;
    logic       invphase;
    logic       freeze;
    logic [1:0] tach;
    logic [7:0] countl;
    logic [7:0] counth;
    logic       dir;
    logic       qerr;

    // Channel control / SPI side: drives strobes and phases, reads the count.
    modport master (
        output filterce, invphase, freeze, tach,
        input  countl, counth, dir, qerr
    );

    // Tach counter side.
    modport slave (
        input  filterce, invphase, freeze, tach,
        output countl, counth, dir, qerr
    );
endinterface
`default_nettype wire

// File: rtl/tach_quad_counter.sv
`default_nettype none
// ============================================================================
//  Module      : tach_quad_counter
//  Description : Quadrature tachometer front end. Synchronises and filters the
//                two tach phases, decodes them at 4x into a 16-bit up/down
//                count and presents it through a freezable output register.
//  Revision    : 1.0  initial release
// ============================================================================
module tach_quad_counter #(
    parameter int FILTLEN = 3
) (
    input  logic                clk,
    input  logic                reset,
    tach_quad_counter_if.slave  bus
);

    localparam logic [3:0] c_FILTLEN = 4'(FILTLEN);

    logic [1:0]  r_sync1;
    logic [1:0]  r_sync2;
    logic [1:0]  w_acc;
    logic [1:0]  r_prev;
    logic [1:0]  w_delta;
    logic        w_step;
    logic        w_up;
    logic        w_illegal;
    logic [15:0] r_count;
    logic [15:0] r_out;
    logic        r_dir;
    logic        r_qerr;

    // Gray phase pair to position in the 00,01,11,10 cycle.
    function automatic logic [1:0] gray2pos(input logic [1:0] g);
        return {g[1], g[1] ^ g[0]};
    endfunction

    // Two-flop synchroniser on both asynchronous tach phases.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 2'b00;
            r_sync2 <= 2'b00;
        end else begin
            r_sync1 <= bus.tach;
            r_sync2 <= r_sync1;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_phase
            logic [3:0] r_run;
            logic       r_acc;

            // Accept a new phase level only after FILTLEN consecutive
            // differing samples; any matching sample restarts the run.
            always_ff @(posedge clk) begin
                if (reset) begin
                    r_run <= 4'd0;
                    r_acc <= 1'b0;
                end else if (bus.filterce) begin
                    if (r_sync2[gi] == r_acc) begin
                        r_run <= 4'd0;
                    end else if (r_run + 4'd1 == c_FILTLEN) begin
                        r_acc <= ~r_acc;
                        r_run <= 4'd0;
                    end else begin
                        r_run <= r_run + 4'd1;
                    end
                end
            end

            assign w_acc[gi] = r_acc;
        end
    endgenerate

    // Position difference modulo 4: 1 = forward, 3 = backward, 2 = both
    // phases moved at once (illegal), 0 = nothing to do.
    assign w_delta = gray2pos(w_acc) - gray2pos(r_prev);

    // Step classification; invphase only matters in the cycle a step decodes.
    always_comb begin
        w_step    = 1'b0;
        w_up      = 1'b0;
        w_illegal = 1'b0;
        case (w_delta)
            2'd1: begin
                w_step = 1'b1;
                w_up   = ~bus.invphase;
            end
            2'd3: begin
                w_step = 1'b1;
                w_up   = bus.invphase;
            end
            2'd2: w_illegal = 1'b1;
            default: ;
        endcase
    end

    // Position counter, direction and sticky quadrature error.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_prev  <= 2'b00;
            r_count <= 16'h0000;
            r_dir   <= 1'b0;
            r_qerr  <= 1'b0;
        end else begin
            r_prev <= w_acc;
            if (w_step) begin
                r_count <= w_up ? r_count + 16'd1 : r_count - 16'd1;
                r_dir   <= w_up;
            end
            if (w_illegal) begin
                r_qerr <= 1'b1;
            end
        end
    end

    // Presented value tracks the counter except while a two-byte read holds it.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out <= 16'h0000;
        end else if (!bus.freeze) begin
            r_out <= r_count;
        end
    end

    assign bus.countl = r_out[7:0];
    assign bus.counth = r_out[15:8];
    assign bus.dir    = r_dir;
    assign bus.qerr   = r_qerr;

endmodule
`default_nettype wire
